// File: rtl/cdb_pkg.sv
// cdb_pkg: shared widths, source ids, result entry type and ROB age helper for the CDB arbiter.
package cdb_pkg;
    localparam int N_SRC  = 4;
    localparam int TAG_W  = 5;
    localparam int REG_W  = 5;
    localparam int DATA_W = 32;
    typedef enum logic [1:0] {SRC_ALU1, SRC_ALU2, SRC_LD1, SRC_LD2} src_id_e;
    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [REG_W-1:0]  dest;
        logic [DATA_W-1:0] data;
    } cdb_entry_t;
    // Modular distance from the commit pointer; wrap-around falls out of the subtraction.
    function automatic logic [TAG_W-1:0] rob_age(input logic [TAG_W-1:0] tag,
                                                 input logic [TAG_W-1:0] commit_p);
        return tag - commit_p;
    endfunction
endpackage

// File: rtl/cdb_age_select.sv
// cdb_age_select: one-hot picks of the oldest and second-oldest valid candidates; equal ages
// resolve to the lower index.
module cdb_age_select
    import cdb_pkg::*;
(
    input  logic [N_SRC-1:0]            valid,
    input  logic [N_SRC-1:0][TAG_W-1:0] age,
    output logic [N_SRC-1:0]            grant0,
    output logic [N_SRC-1:0]            grant1,
    output logic                        grant0_v,
    output logic                        grant1_v
);
    localparam int RW = $clog2(N_SRC) + 1;
    logic [RW-1:0] rank [N_SRC];
    // rank = number of valid candidates strictly ahead of this one
    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            rank[i] = '0;
            for (int j = 0; j < N_SRC; j++)
                if (j != i && valid[j] && (age[j] < age[i] || (age[j] == age[i] && j < i)))
                    rank[i] = rank[i] + RW'(1);
        end
    end
    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            grant0[i] = valid[i] && rank[i] == RW'(0);
            grant1[i] = valid[i] && rank[i] == RW'(1);
        end
    end
    assign grant0_v = |grant0;
    assign grant1_v = |grant1;
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: four producers onto two writeback buses, oldest ROB age first, 1-entry hold per source.
// CDB_BYPASS_EN lets an empty source's new result arbitrate in the same cycle it arrives.
module cdb_arbiter
    import cdb_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [TAG_W-1:0]        commit_p,
    input  logic [N_SRC-1:0]        src_valid,
    input  logic [N_SRC*TAG_W-1:0]  src_tag,
    input  logic [N_SRC*REG_W-1:0]  src_dest,
    input  logic [N_SRC*DATA_W-1:0] src_data,
    output logic [N_SRC-1:0]        src_ready,
    output logic                    wb0_valid,
    output logic [TAG_W-1:0]        wb0_tag,
    output logic [REG_W-1:0]        wb0_dest,
    output logic [DATA_W-1:0]       wb0_data,
    output logic                    wb1_valid,
    output logic [TAG_W-1:0]        wb1_tag,
    output logic [REG_W-1:0]        wb1_dest,
    output logic [DATA_W-1:0]       wb1_data
);
    cdb_entry_t [N_SRC-1:0]      src_in, cand_e, pend_q, pend_d;
    logic [N_SRC-1:0]            pend_v_q, pend_v_d, cand_v, grant0, grant1, grant, accept;
    logic [N_SRC-1:0][TAG_W-1:0] cand_age;
    logic                        grant0_v, grant1_v, dup;
    cdb_entry_t                  wb0_q, wb0_d, wb1_q, wb1_d;
    logic                        wb0_v_q, wb0_v_d, wb1_v_q, wb1_v_d;

    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            src_in[i] = {src_tag[i*TAG_W +: TAG_W], src_dest[i*REG_W +: REG_W],
                         src_data[i*DATA_W +: DATA_W]};
`ifdef CDB_BYPASS_EN
            cand_v[i] = pend_v_q[i] | src_valid[i];
`else
            cand_v[i] = pend_v_q[i];
`endif
            cand_e[i]   = pend_v_q[i] ? pend_q[i] : src_in[i];
            cand_age[i] = rob_age(cand_e[i].tag, commit_p);
        end
    end

    cdb_age_select u_sel (
        .valid    (cand_v),
        .age      (cand_age),
        .grant0   (grant0),
        .grant1   (grant1),
        .grant0_v (grant0_v),
        .grant1_v (grant1_v)
    );

    assign grant     = flush ? '0 : (grant0 | grant1);
    assign src_ready = ~pend_v_q | grant | {N_SRC{flush}};
    assign accept    = src_valid & src_ready & ~{N_SRC{flush}};

    always_comb begin
        pend_d   = pend_q;
        pend_v_d = pend_v_q & ~grant;
        for (int i = 0; i < N_SRC; i++)
            if (accept[i]) begin
                pend_d[i] = src_in[i];
`ifdef CDB_BYPASS_EN
                // a bypassed winner never lands in its holding register
                pend_v_d[i] = pend_v_q[i] | ~grant[i];
`else
                pend_v_d[i] = 1'b1;
`endif
            end
        if (flush)
            pend_v_d = '0;
    end

    always_comb begin
        wb0_d = '0;
        wb1_d = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (grant0[i])
                wb0_d = cand_e[i];
            if (grant1[i])
                wb1_d = cand_e[i];
        end
        wb0_v_d = grant0_v & ~flush;
        wb1_v_d = grant1_v & ~flush;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_v_q <= '0;
            pend_q   <= '0;
            wb0_v_q  <= 1'b0;
            wb1_v_q  <= 1'b0;
            wb0_q    <= '0;
            wb1_q    <= '0;
        end else begin
            pend_v_q <= pend_v_d;
            pend_q   <= pend_d;
            wb0_v_q  <= wb0_v_d;
            wb1_v_q  <= wb1_v_d;
            wb0_q    <= wb0_d;
            wb1_q    <= wb1_d;
        end
    end

    always_comb begin
        dup = 1'b0;
        for (int i = 0; i < N_SRC; i++)
            for (int j = i + 1; j < N_SRC; j++)
                if (cand_v[i] && cand_v[j] && cand_e[i].tag == cand_e[j].tag)
                    dup = 1'b1;
    end

    a_unique_tag: assert property (@(posedge clk) disable iff (rst) !dup);

    assign wb0_valid = wb0_v_q;
    assign wb0_tag   = wb0_q.tag;
    assign wb0_dest  = wb0_q.dest;
    assign wb0_data  = wb0_q.data;
    assign wb1_valid = wb1_v_q;
    assign wb1_tag   = wb1_q.tag;
    assign wb1_dest  = wb1_q.dest;
    assign wb1_data  = wb1_q.data;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed vectors with hand-computed expectations for cdb_arbiter.
module tb_cdb_arbiter;
`ifdef CDB_BYPASS_EN
    localparam int         LAT      = 1;
    localparam logic [3:0] RDY_WAIT = 4'b1111;
`else
    localparam int         LAT      = 2;
    localparam logic [3:0] RDY_WAIT = 4'b0110;
`endif
    logic        clk = 1'b0;
    logic        rst, flush;
    logic [4:0]  commit_p;
    logic [3:0]  src_valid, src_ready;
    logic [19:0] src_tag, src_dest;
    logic [127:0] src_data;
    logic        wb0_valid, wb1_valid;
    logic [4:0]  wb0_tag, wb0_dest, wb1_tag, wb1_dest;
    logic [31:0] wb0_data, wb1_data;
    int checks = 0;
    int errors = 0;

    cdb_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .commit_p  (commit_p),
        .src_valid (src_valid),
        .src_tag   (src_tag),
        .src_dest  (src_dest),
        .src_data  (src_data),
        .src_ready (src_ready),
        .wb0_valid (wb0_valid),
        .wb0_tag   (wb0_tag),
        .wb0_dest  (wb0_dest),
        .wb0_data  (wb0_data),
        .wb1_valid (wb1_valid),
        .wb1_tag   (wb1_tag),
        .wb1_dest  (wb1_dest),
        .wb1_data  (wb1_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int i, input logic [4:0] tag, input logic [4:0] dest, input logic [31:0] data);
        src_valid[i]          = 1'b1;
        src_tag[i*5 +: 5]     = tag;
        src_dest[i*5 +: 5]    = dest;
        src_data[i*32 +: 32]  = data;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; commit_p = '0;
        src_valid = '0; src_tag = '0; src_dest = '0; src_data = '0;
        tick(); tick();
        check("rst_wb0_v", wb0_valid, 0);
        check("rst_wb1_v", wb1_valid, 0);
        check("rst_wb0_tag", wb0_tag, 0);
        check("rst_wb0_data", wb0_data, 0);
        check("rst_ready", src_ready, 4'hf);
        rst = 1'b0;

        // single result
        put(0, 5'd3, 5'd7, 32'hAB);
        tick();
        src_valid = '0;
        repeat (LAT - 1) tick();
        check("t1_wb0_v", wb0_valid, 1);
        check("t1_wb0_tag", wb0_tag, 3);
        check("t1_wb0_dest", wb0_dest, 7);
        check("t1_wb0_data", wb0_data, 32'hAB);
        check("t1_wb1_v", wb1_valid, 0);
        tick();
        check("t1_one_cycle", wb0_valid, 0);

        // four at once
        put(0, 5'd9, 5'd10, 32'h90);
        put(1, 5'd2, 5'd11, 32'h20);
        put(2, 5'd5, 5'd12, 32'h50);
        put(3, 5'd7, 5'd13, 32'h70);
        #1 check("t2_rdy_in", src_ready, 4'hf);
        tick();
        src_valid = '0;
        #1 check("t2_rdy_wait", src_ready, RDY_WAIT);
        repeat (LAT - 1) tick();
        check("t2a_wb0_tag", wb0_tag, 2);
        check("t2a_wb0_dest", wb0_dest, 11);
        check("t2a_wb0_data", wb0_data, 32'h20);
        check("t2a_wb1_tag", wb1_tag, 5);
        check("t2a_valids", {wb0_valid, wb1_valid}, 2'b11);
        tick();
        check("t2b_wb0_tag", wb0_tag, 7);
        check("t2b_wb1_tag", wb1_tag, 9);
        check("t2b_wb1_data", wb1_data, 32'h90);
        check("t2b_valids", {wb0_valid, wb1_valid}, 2'b11);
        tick();
        check("t2_drained", {wb0_valid, wb1_valid}, 2'b00);

        // wrap-around ages
        commit_p = 5'd30;
        put(1, 5'd31, 5'd1, 32'h31);
        put(2, 5'd1, 5'd2, 32'h01);
        tick();
        src_valid = '0;
        repeat (LAT - 1) tick();
        check("t3_wb0_tag", wb0_tag, 31);
        check("t3_wb1_tag", wb1_tag, 1);
        check("t3_wb1_dest", wb1_dest, 2);
        check("t3_valids", {wb0_valid, wb1_valid}, 2'b11);
        tick();
        check("t3_drained", {wb0_valid, wb1_valid}, 2'b00);

        // back-to-back stream on ALU1
        commit_p = '0;
        for (int c = 0; c < 8 + LAT - 1; c++) begin
            src_valid[0] = (c < 8);
            src_tag[4:0] = c[4:0];
            src_data[31:0] = 32'h100 + c;
            #1 if (c < 8) check("t4_rdy", src_ready[0], 1);
            tick();
            if (c >= LAT - 1) begin
                check("t4_wb0_v", wb0_valid, 1);
                check("t4_wb0_tag", wb0_tag, c - LAT + 1);
                check("t4_wb1_v", wb1_valid, 0);
            end
        end
        src_valid = '0;
        tick();
        check("t4_drained", wb0_valid, 0);

        // flush with entries pending and a new result arriving on the flush edge
        put(0, 5'd10, 5'd1, 32'hA0);
        put(1, 5'd11, 5'd2, 32'hA1);
        put(2, 5'd12, 5'd3, 32'hA2);
        tick();
        src_valid = '0;
        flush = 1'b1;
        put(3, 5'd20, 5'd4, 32'hA3);
        #1 check("t5_rdy_flush", src_ready, 4'hf);
        tick();
        flush = 1'b0;
        src_valid = '0;
        check("t5_wb_after", {wb0_valid, wb1_valid}, 2'b00);
        #1 check("t5_rdy_after", src_ready, 4'hf);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("t5_quiet", {wb0_valid, wb1_valid}, 2'b00);
        end

        // idle arbiter, single LD2 result: latency check
        put(3, 5'd4, 5'd3, 32'h44);
        tick();
        src_valid = '0;
        repeat (LAT - 1) tick();
        check("t6_wb0_v", wb0_valid, 1);
        check("t6_wb0_tag", wb0_tag, 4);
        check("t6_wb0_data", wb0_data, 32'h44);
        check("t6_wb1_v", wb1_valid, 0);
        tick();
        check("t6_one_cycle", wb0_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
